// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scanner.
// Digit count, nibble width and the anode-off pattern live here.
package ssd_pkg;

  localparam int DIGITS = 4;
  localparam int NIB_W  = 4;
  localparam int VAL_W  = DIGITS * NIB_W;

  localparam logic [DIGITS-1:0] ANODE_OFF = '1;

  typedef logic [$clog2(DIGITS)-1:0] idx_t;

  // Active-low one-cold anode pattern for digit k.
  function automatic logic [DIGITS-1:0] anode_sel(input idx_t k);
    logic [DIGITS-1:0] one;
    one = 1;
    return ~(one << k);
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Refresh prescaler: counts 0..P_REFRESH_DIV-1 while enabled.
// Emits a one-cycle tick on the terminal count, then wraps.
module ssd_tick_gen #(
  parameter int P_REFRESH_DIV = 100000
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_En,
  output logic o_Tick
);

  localparam int W = $clog2(P_REFRESH_DIV);
  localparam logic [W-1:0] LAST = W'(P_REFRESH_DIV - 1);

  logic [W-1:0] r_Cnt;
  logic         w_Term;

  assign w_Term = (r_Cnt == LAST);
  assign o_Tick = i_En & w_Term;

  // Count while enabled; hold the value while disabled.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_Cnt <= '0;
    end else if (i_En) begin
      r_Cnt <= w_Term ? '0 : r_Cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan.sv
// Four-digit multiplexed display scanner with frame-atomic updates.
// Nibble leaves after one stage; anodes/DP after two to meet decoder.
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int P_REFRESH_DIV = 100000
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_En,
  input  logic [VAL_W-1:0]  i_Value,
  input  logic              i_Load,
  input  logic [DIGITS-1:0] i_DP,
  input  logic              i_Blank_En,
  output logic [NIB_W-1:0]  o_Num,
  output logic [DIGITS-1:0] o_Anodes,
  output logic              o_DP,
  output logic              o_Frame
);

  logic              w_Tick;
  logic              w_Wrap;
  logic              w_Blank;
  logic [NIB_W-1:0]  w_Nib;
  idx_t              r_Idx;
  logic [VAL_W-1:0]  r_PendVal;
  logic [VAL_W-1:0]  r_ActVal;
  logic [DIGITS-1:0] r_PendDp;
  logic [DIGITS-1:0] r_ActDp;
  logic [NIB_W-1:0]  r_Num;
  logic [DIGITS-1:0] r_S1An;
  logic              r_S1Dp;
  logic [DIGITS-1:0] r_Anodes;
  logic              r_DP;
  logic              r_Frame;

  ssd_tick_gen #(
    .P_REFRESH_DIV(P_REFRESH_DIV)
  ) u_tick (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .i_En  (i_En),
    .o_Tick(w_Tick)
  );

  assign w_Wrap = w_Tick && (r_Idx == idx_t'(DIGITS - 1));
  assign w_Nib  = r_ActVal[r_Idx*NIB_W +: NIB_W];

  // Digit k>=1 goes dark when it and every higher nibble are zero.
  always_comb begin
    w_Blank = 1'b0;
    if (i_Blank_En && (r_Idx != '0)) begin
      w_Blank = ((r_ActVal >> (NIB_W * r_Idx)) == '0);
    end
  end

  // Digit index advances once per refresh tick.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_Idx <= '0;
    end else if (w_Tick) begin
      r_Idx <= r_Idx + 1'b1;
    end
  end

  // Pending/active value; active only changes between frames.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_PendVal <= '0;
      r_PendDp  <= '0;
      r_ActVal  <= '0;
      r_ActDp   <= '0;
    end else begin
      if (i_Load) begin
        r_PendVal <= i_Value;
        r_PendDp  <= i_DP;
      end
      if (w_Wrap) begin
        r_ActVal <= i_Load ? i_Value : r_PendVal;
        r_ActDp  <= i_Load ? i_DP : r_PendDp;
      end
    end
  end

  // Stage 1: nibble plus pre-delayed anode/DP pattern.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_Num  <= '0;
      r_S1An <= ANODE_OFF;
      r_S1Dp <= 1'b1;
    end else begin
      r_Num <= w_Nib;
      if (!i_En || w_Blank) begin
        r_S1An <= ANODE_OFF;
        r_S1Dp <= 1'b1;
      end else begin
        r_S1An <= anode_sel(r_Idx);
        r_S1Dp <= ~r_ActDp[r_Idx];
      end
    end
  end

  // Stage 2: anodes/DP aligned with the decoder's registered cathodes.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_Anodes <= ANODE_OFF;
      r_DP     <= 1'b1;
      r_Frame  <= 1'b0;
    end else begin
      r_Anodes <= r_S1An;
      r_DP     <= r_S1Dp;
      r_Frame  <= w_Wrap;
    end
  end

  assign o_Num    = r_Num;
  assign o_Anodes = r_Anodes;
  assign o_DP     = r_DP;
  assign o_Frame  = r_Frame;

endmodule

// File: tb/tb_ssd_scan.sv
// Testbench for ssd_scan: directed scenarios plus random traffic.
// A slot-position reference model predicts every output each cycle.
module tb_ssd_scan;

  localparam int DIV  = 4;
  localparam int FLEN = 4 * DIV;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] val;
  logic        load;
  logic [3:0]  dp;
  logic        blank;
  logic [3:0]  o_Num;
  logic [3:0]  o_Anodes;
  logic        o_DP;
  logic        o_Frame;

  int n_checks;
  int n_errors;

  // reference model state
  int          m_pos;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;
  logic [3:0]  e_num, e_an, s1_an;
  logic        e_dp, s1_dp, e_frame;

  ssd_scan #(
    .P_REFRESH_DIV(DIV)
  ) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_En      (en),
    .i_Value   (val),
    .i_Load    (load),
    .i_DP      (dp),
    .i_Blank_En(blank),
    .o_Num     (o_Num),
    .o_Anodes  (o_Anodes),
    .o_DP      (o_DP),
    .o_Frame   (o_Frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t",
             tag, obs, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge,
  // then compare all outputs 1 time unit later.
  task automatic step();
    int   d;
    logic blk;
    logic wrap;
    @(posedge clk);
    if (rst) begin
      m_pos = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
      e_num = '0; s1_an = 4'hF; s1_dp = 1'b1;
      e_an = 4'hF; e_dp = 1'b1; e_frame = 1'b0;
    end else begin
      e_an = s1_an;
      e_dp = s1_dp;
      d = m_pos / DIV;
      e_num = 4'((m_act >> (4 * d)) & 16'hF);
      blk = blank && (d > 0) && ((m_act >> (4 * d)) == 16'h0);
      if (!en || blk) begin
        s1_an = 4'hF;
        s1_dp = 1'b1;
      end else begin
        s1_an = 4'hF ^ (4'b0001 << d);
        s1_dp = !m_adp[d];
      end
      wrap = en && (m_pos == FLEN - 1);
      e_frame = wrap;
      if (wrap) begin
        m_act = load ? val : m_pend;
        m_adp = load ? dp : m_pdp;
      end
      if (load) begin
        m_pend = val;
        m_pdp = dp;
      end
      if (en) m_pos = (m_pos + 1) % FLEN;
    end
    #1;
    chk("num", {12'h0, o_Num}, {12'h0, e_num});
    chk("anodes", {12'h0, o_Anodes}, {12'h0, e_an});
    chk("dp", {15'h0, o_DP}, {15'h0, e_dp});
    chk("frame", {15'h0, o_Frame}, {15'h0, e_frame});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    val = v; dp = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Advance until the model's next edge is at slot position p.
  task automatic wait_pos(input int p);
    int guard;
    guard = 0;
    while (m_pos != p && guard < 64) begin
      step();
      guard++;
    end
    chk("wait_pos_timeout", 16'(guard < 64), 16'h1);
  endtask

  initial begin
    int frames;
    int lit;
    n_checks = 0; n_errors = 0;
    m_pos = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    e_num = '0; s1_an = 4'hF; s1_dp = 1'b1;
    e_an = 4'hF; e_dp = 1'b1; e_frame = 1'b0;
    rst = 1'b1; en = 1'b1; val = '0; load = 1'b0; dp = '0; blank = 1'b0;

    // reset held 3 cycles, then one cycle after release
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_an", {12'h0, o_Anodes}, 16'hF);
      chk("rst_num", {12'h0, o_Num}, 16'h0);
      chk("rst_dp", {15'h0, o_DP}, 16'h1);
      chk("rst_frame", {15'h0, o_Frame}, 16'h0);
    end
    rst = 1'b0;
    step();
    chk("rel_an", {12'h0, o_Anodes}, 16'hF);
    chk("rel_num", {12'h0, o_Num}, 16'h0);

    // basic scan of 0x12AB with DP on digit 2
    do_load(16'h12AB, 4'b0100);
    run(40);
    frames = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (o_Frame) frames++;
    end
    chk("frame_rate", 16'(frames), 16'd2);

    // load mid-frame during digit-1 slot
    wait_pos(DIV);
    do_load(16'h1111, 4'b0000);
    run(40);

    // load coinciding with the wrap tick
    do_load(16'h12AB, 4'b0100);
    wait_pos(FLEN - 1);
    do_load(16'h0F0F, 4'b0000);
    step();
    chk("wrap_load_num", {12'h0, o_Num}, 16'hF);
    run(20);

    // leading-zero blanking
    blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    run(40);
    do_load(16'h0000, 4'b1111);
    run(40);
    lit = 0;
    for (int i = 0; i < FLEN; i++) begin
      step();
      if (o_Anodes != 4'hF) lit++;
    end
    chk("blank_zero_lit", 16'(lit), 16'(DIV));
    blank = 1'b0;

    // reset during the digit-2 slot
    do_load(16'h12AB, 4'b0100);
    run(20);
    wait_pos(2 * DIV + 1);
    rst = 1'b1;
    step();
    chk("mid_rst_an", {12'h0, o_Anodes}, 16'hF);
    chk("mid_rst_num", {12'h0, o_Num}, 16'h0);
    rst = 1'b0;
    do_load(16'h12AB, 4'b0100);
    run(20);

    // scan enable low for 10 cycles
    en = 1'b0;
    run(2);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("dark_an", {12'h0, o_Anodes}, 16'hF);
    end
    en = 1'b1;
    run(20);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 9) != 0);
      blank = ($urandom_range(0, 1) == 1);
      load  = ($urandom_range(0, 7) == 0);
      val   = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                          : 16'($urandom_range(0, 255));
      dp    = 4'($urandom);
      step();
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan.md
SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 SHALL have parameter P_REFRESH_DIV, default 100000, meaning clock cycles per digit slot (minimum 2).
REQ-002 SHALL have port i_CLK  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port i_RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_En  input  1  scan enable; low = display dark, counters held.
REQ-005 SHALL have port i_Value  input  16  four hex digits; digit k = i_Value[4k+3:4k].
REQ-006 SHALL have port i_Load  input  1  one-cycle strobe capturing i_Value and i_DP into pending registers.
REQ-007 SHALL have port i_DP  input  4  per-digit decimal point request, bit k = digit k, active-high.
REQ-008 SHALL have port i_Blank_En  input  1  leading-zero suppression enable.
REQ-009 SHALL have port o_Num  output  4  nibble for the downstream registered hex-to-cathode decoder.
REQ-010 SHALL have port o_Anodes  output  4  digit enables, active-low, bit k = digit k.
REQ-011 SHALL have port o_DP  output  1  decimal-point cathode, active-low.
REQ-012 SHALL have port o_Frame  output  1  one-cycle pulse when a full 4-digit scan completes.

Function
REQ-013 SHALL run a prescaler counting 0..P_REFRESH_DIV-1 while i_En=1, producing a one-cycle tick at terminal count, then wrapping to 0.
REQ-014 SHALL hold a 2-bit digit index that increments on tick (0->1->2->3->0).
REQ-015 SHALL assert o_Frame for exactly one cycle on the tick where the index wraps 3->0.
REQ-016 SHALL hold pending and active value/DP registers. i_Load writes pending. Pending copies to active on the wrap tick only, so no frame ever mixes two values.
REQ-017 SHALL, when i_Load and the wrap tick coincide, write i_Value/i_DP straight into active, so the new value shows from digit 0.
REQ-018 SHALL register o_Num = active nibble[index], valid one cycle after the index changes (stage 1).
REQ-019 SHALL delay the anode and DP pattern by two cycles relative to the index change, matching o_Num plus the decoder's one-cycle register latency. Cathodes and anodes then change on the same edge.
REQ-020 SHALL drive the digit-k anode pattern as all ones except bit k = 0, unless digit k is blanked.
REQ-021 SHALL, when i_Blank_En=1, blank digit k (k>=1; anodes 4'b1111, o_DP=1) when all active nibbles k..3 are zero. Digit 0 is never blanked.
REQ-022 SHALL drive o_DP = ~active_DP[k] in the digit-k slot.
REQ-023 SHALL, when i_En=0, hold the prescaler and index and force o_Anodes=4'b1111 and o_DP=1 within two cycles. Loads are still accepted.
REQ-024 SHALL resume from the held index and prescaler value when i_En returns high.

Reset
REQ-025 SHALL, on i_RST=1 at a clock edge, set the prescaler, index, pending, active and o_Num to 0; o_Anodes to 4'b1111; o_DP to 1; o_Frame to 0; and clear both pipeline stages. This applies mid-scan and overrides a simultaneous i_Load.
REQ-026 SHALL start from digit 0 with a full slot after reset releases.

Structure
REQ-027 SHALL take the digit count (4), the anode-off constant (4'b1111) and the nibble width from a shared package ssd_pkg.
REQ-028 SHALL implement the prescaler as sub-module ssd_tick_gen (parameter P_REFRESH_DIV; ports i_CLK, i_RST, i_En, o_Tick).
REQ-029 SHALL NOT instantiate the decoder; the decoder is instantiated beside this block at display top level.

Verification (P_REFRESH_DIV=4)
REQ-030 Reset held 3 cycles -> o_Anodes=1111, o_Num=0, o_DP=1, o_Frame=0 throughout and one cycle after release.
REQ-031 Load 0x12AB, i_DP=4'b0100, blank off, i_En=1 -> o_Num B,A,2,1 each held 4 cycles; o_Anodes 1110,1101,1011,0111 one cycle behind o_Num; o_DP=0 only in the digit-2 slot; o_Frame pulses every 16 cycles.
REQ-032 Blank on: load 0x0050 -> digit 3 and 2 slots give anodes 1111; digits 1 and 0 are shown. Load 0x0000 -> only the digit-0 slot is active (1110).
REQ-033 Load 0x1111 during the digit-1 slot of a 0x12AB frame -> that frame finishes 0x12AB; the next frame shows 1,1,1,1.
REQ-034 Load 0x0F0F on the same cycle as the wrap tick -> o_Num=F in the immediately following digit-0 slot.
REQ-035 Assert i_RST during the digit-2 slot -> next cycle matches REQ-025; scan restarts at digit 0. i_En low for 10 cycles -> anodes 1111, index frozen, then resumes.
